// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: streams activations against weight memory, adds bias, emits one Q-format result.
// Build option: define NEURON_RELU_EN for a ReLU output (hidden layers); otherwise the output is signed linear.
module neuron_mac #(
  parameter int                            numWeights = 784,
  parameter int                            addrWidth  = 10,
  parameter int                            dataWidth  = 16,
  parameter int                            fracBits   = 8,
  parameter logic signed [dataWidth-1:0]   biasValue  = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [dataWidth-1:0]   in_data,
  output logic                          ren,
  output logic [addrWidth-1:0]          raddr,
  input  logic signed [dataWidth-1:0]   wout,
  output logic                          out_valid,
  output logic signed [dataWidth-1:0]   out_data
);

  localparam int ACC_W = 2 * dataWidth + 8;
  localparam logic [addrWidth-1:0]      LAST_IDX = addrWidth'(numWeights - 1);
  localparam logic signed [ACC_W-1:0]   ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]   ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [dataWidth-1:0] DATA_MAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic signed [dataWidth-1:0] DATA_MIN = {1'b1, {(dataWidth-1){1'b0}}};

  typedef enum logic [1:0] {ST_ACCUM, ST_WAIT, ST_BIAS, ST_OUT} state_t;

  state_t                        r_state;
  logic [addrWidth-1:0]          r_cnt;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [dataWidth-1:0]   r_x_d;
  logic                          r_mul_vld;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic signed [dataWidth-1:0]   r_out_data;

  logic                          w_accept;
  logic signed [2*dataWidth-1:0] w_prod;
  logic signed [ACC_W-1:0]       w_prod_ext;
  logic signed [ACC_W-1:0]       w_bias_ext;
  logic signed [ACC_W-1:0]       w_shifted;
  logic [ACC_W-dataWidth:0]      w_upper;
  logic signed [dataWidth-1:0]   w_sat;
  logic signed [dataWidth-1:0]   w_result;

  function automatic logic signed [ACC_W-1:0] f_sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign w_accept   = in_valid && r_in_ready;
  assign w_prod     = r_x_d * wout;
  assign w_prod_ext = {{(ACC_W-2*dataWidth){w_prod[2*dataWidth-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-dataWidth-fracBits){biasValue[dataWidth-1]}}, biasValue, {fracBits{1'b0}}};
  assign w_shifted  = r_acc >>> fracBits;
  // The shifted value fits the output width only when all bits above its sign bit match it.
  assign w_upper    = w_shifted[ACC_W-1:dataWidth-1];

  always_comb begin
    w_sat = w_shifted[dataWidth-1:0];
    if (!((&w_upper) || (~|w_upper))) w_sat = w_shifted[ACC_W-1] ? DATA_MIN : DATA_MAX;
  end

`ifdef NEURON_RELU_EN
  assign w_result = w_sat[dataWidth-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_x_d       <= '0;
      r_mul_vld   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_mul_vld   <= w_accept;
      if (w_accept) begin
        r_x_d <= in_data;
        r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
      end
      case (r_state)
        ST_ACCUM: begin
          if (r_mul_vld) r_acc <= f_sat_add(r_acc, w_prod_ext);
          if (w_accept && (r_cnt == LAST_IDX)) begin
            r_in_ready <= 1'b0;
            r_state    <= ST_WAIT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        // The final product lands here, one edge after its sample was accepted.
        ST_WAIT: begin
          if (r_mul_vld) r_acc <= f_sat_add(r_acc, w_prod_ext);
          r_state <= ST_BIAS;
        end
        ST_BIAS: begin
          r_acc   <= f_sat_add(r_acc, w_bias_ext);
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_ACCUM;
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign ren       = w_accept;
  assign raddr     = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: three instances differing only in bias share one stimulus stream.
module tb_neuron_mac;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic in_ready [NI];
  logic ren [NI];
  logic out_valid [NI];
  logic [AW-1:0] raddr [NI];
  logic signed [DW-1:0] wout [NI];
  logic signed [DW-1:0] out_data [NI];
  logic signed [DW-1:0] weights [8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_idx = 0;
  int last_acc_cyc = 0;
  int low_cnt = 0;
  int res_cnt [NI];
  int res_data [NI][16];
  int res_cyc [NI][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam logic signed [DW-1:0] BV = (gi == 0) ? 16'sd0 : (gi == 1) ? 16'sd128 : -16'sd512;
      neuron_mac #(.numWeights(NW), .addrWidth(AW), .dataWidth(DW), .fracBits(FB), .biasValue(BV)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[gi]), .in_data(in_data),
        .ren(ren[gi]), .raddr(raddr[gi]), .wout(wout[gi]), .out_valid(out_valid[gi]), .out_data(out_data[gi]));
      always @(posedge clk) if (ren[gi]) wout[gi] <= weights[raddr[gi]];
    end
  endgenerate

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (out_valid[k] === 1'b1) begin
        res_data[k][res_cnt[k] % 16] = out_data[k];
        res_cyc[k][res_cnt[k] % 16]  = cyc;
        res_cnt[k]++;
      end
    end
    if (rst_n && in_ready[0] !== 1'b1) low_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int bias_of(input int k);
    if (k == 0) return 0;
    if (k == 1) return 128;
    return -512;
  endfunction

  // Reference: exact dot product with accumulator clamping, bias in Q format, floor shift, output clamp.
  function automatic int model(input int xs[NW], input int ws[NW], input int bias);
    longint acc = 0;
    longint amax = (longint'(1) <<< 39) - 1;
    longint amin = -(longint'(1) <<< 39);
    longint r;
    for (int i = 0; i < NW; i++) begin
      acc = acc + longint'(xs[i]) * longint'(ws[i]);
      if (acc > amax) acc = amax;
      if (acc < amin) acc = amin;
    end
    acc = acc + longint'(bias) * 256;
    if (acc > amax) acc = amax;
    if (acc < amin) acc = amin;
    r = acc >>> FB;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef NEURON_RELU_EN
    if (r < 0) r = 0;
`endif
    return int'(r);
  endfunction

  task automatic set_weights(input int ws[NW]);
    for (int i = 0; i < NW; i++) weights[i] = DW'(ws[i]);
    for (int i = NW; i < 8; i++) weights[i] = 16'sd12345;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input int x);
    int n = 0;
    in_valid = 1'b1;
    in_data = DW'($urandom);
    @(negedge clk);
    while (in_ready[0] !== 1'b1 && n < 50) begin
      in_data = DW'($urandom);
      n++;
      @(negedge clk);
    end
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready[0]);
    end
    in_data = DW'(x);
    #1;
    checks++;
    if (raddr[0] !== AW'(exp_idx) || ren[0] !== 1'b1) begin
      errors++;
      $display("FAIL raddr_ren: raddr=%0d ren=%b required raddr=%0d ren=1", raddr[0], ren[0], exp_idx);
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    exp_idx = (exp_idx + 1) % NW;
  endtask

  task automatic send_vector(input int xs[NW], input bit gaps);
    for (int i = 0; i < NW; i++) begin
      send_sample(xs[i]);
      if (gaps && ($urandom % 2 == 1) && i < NW - 1) idle($urandom_range(1, 3));
    end
  endtask

  task automatic wait_result(input int base, input int n, input string name);
    int t = 0;
    in_valid = 1'b0;
    while (res_cnt[0] < base + n && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (res_cnt[0] < base + n) begin
      errors++;
      $display("FAIL %s_timeout: results=%0d required %0d", name, res_cnt[0] - base, n);
    end
  endtask

  task automatic check_results(input int base, input int j, input int xs[NW], input int ws[NW], input string name);
    for (int k = 0; k < NI; k++) begin
      int e = model(xs, ws, bias_of(k));
      int g = res_data[k][(base + j) % 16];
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s_data inst%0d vec%0d: out_data=%0d required %0d", name, k, j, g, e);
      end else begin
        $display("vector %s inst%0d vec%0d: out_data=%0d ok", name, k, j, g);
      end
    end
  endtask

  task automatic run_vector(input string name, input int ws[NW], input int xs[NW], input bit gaps);
    int base = res_cnt[0];
    int c0;
    set_weights(ws);
    send_vector(xs, gaps);
    c0 = last_acc_cyc;
    wait_result(base, 1, name);
    check_results(base, 0, xs, ws, name);
    checks++;
    if (res_cyc[0][base % 16] - c0 !== 3) begin
      errors++;
      $display("FAIL %s_latency: edges=%0d required 3", name, res_cyc[0][base % 16] - c0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (res_cnt[0] !== base + 1 || out_data[0] !== DW'(model(xs, ws, 0))) begin
      errors++;
      $display("FAIL %s_pulse_hold: results=%0d out_data=%0d required 1 and %0d",
               name, res_cnt[0] - base, out_data[0], model(xs, ws, 0));
    end
  endtask

  task automatic check_reset_values(input string name);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || out_data[k] !== '0 || in_ready[k] !== 1'b0 || ren[k] !== 1'b0 || raddr[k] !== '0) begin
        errors++;
        $display("FAIL %s inst%0d: ov=%b od=%0d rdy=%b ren=%b raddr=%0d required all 0",
                 name, k, out_valid[k], out_data[k], in_ready[k], ren[k], raddr[k]);
      end
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready[0]);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: in_ready=%b required 1", in_ready[0]);
    end
    exp_idx = 0;
  endtask

  task automatic test_basic;
    run_vector("basic", '{256, 256, 256, 256}, '{256, 512, -256, 256}, 1'b0);
  endtask

  task automatic test_negative;
    run_vector("negative", '{256, 256, 256, 256}, '{-256, -256, -256, -256}, 1'b0);
  endtask

  task automatic test_bias;
    run_vector("bias", '{256, 256, 256, 256}, '{64, 64, 64, 64}, 1'b0);
  endtask

  task automatic test_saturation;
    run_vector("sat_pos", '{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}, 1'b0);
    run_vector("sat_neg", '{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767}, 1'b0);
  endtask

  task automatic test_back_to_back;
    int ws[NW];
    int x1[NW];
    int x2[NW];
    int base = res_cnt[0];
    int low0 = low_cnt;
    for (int i = 0; i < NW; i++) begin
      ws[i] = $urandom_range(0, 4095) - 2048;
      x1[i] = $urandom_range(0, 4095) - 2048;
      x2[i] = $urandom_range(0, 4095) - 2048;
    end
    set_weights(ws);
    send_vector(x1, 1'b0);
    send_vector(x2, 1'b0);
    wait_result(base, 2, "b2b");
    repeat (3) @(posedge clk);
    #1;
    check_results(base, 0, x1, ws, "b2b");
    check_results(base, 1, x2, ws, "b2b");
    checks++;
    if (low_cnt - low0 !== 6 || res_cnt[0] !== base + 2) begin
      errors++;
      $display("FAIL b2b_ready_low: low_cycles=%0d results=%0d required 6 and 2", low_cnt - low0, res_cnt[0] - base);
    end
  endtask

  task automatic test_random_gaps;
    int ws[NW];
    int xs[3][NW];
    int base = res_cnt[0];
    int low0 = low_cnt;
    for (int i = 0; i < NW; i++) ws[i] = $urandom_range(0, 65535) - 32768;
    for (int v = 0; v < 3; v++)
      for (int i = 0; i < NW; i++) xs[v][i] = $urandom_range(0, 2047) - 1024;
    set_weights(ws);
    for (int v = 0; v < 3; v++) begin
      send_vector(xs[v], 1'b1);
      if ($urandom % 2 == 1) idle($urandom_range(1, 2));
    end
    wait_result(base, 3, "gaps");
    repeat (3) @(posedge clk);
    #1;
    for (int v = 0; v < 3; v++) check_results(base, v, xs[v], ws, "gaps");
    checks++;
    if (low_cnt - low0 !== 9 || res_cnt[0] !== base + 3) begin
      errors++;
      $display("FAIL gaps_ready_low: low_cycles=%0d results=%0d required 9 and 3", low_cnt - low0, res_cnt[0] - base);
    end
  endtask

  task automatic test_reset_mid_vector;
    int base;
    set_weights('{256, 256, 256, 256});
    base = res_cnt[0];
    send_sample(256);
    send_sample(256);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset_async");
    repeat (3) @(negedge clk);
    check_reset_values("midreset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_idx = 0;
    checks++;
    if (res_cnt[0] !== base) begin
      errors++;
      $display("FAIL midreset_aborted: results=%0d required 0", res_cnt[0] - base);
    end
    run_vector("midreset", '{256, 256, 256, 256}, '{256, 256, 256, 256}, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_bias;
    test_saturation;
    test_back_to_back;
    test_random_gaps;
    test_reset_mid_vector;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
Single-neuron multiply-accumulate stage that consumes the weight memory. It drives the memory's read enable and address, and multiplies each incoming activation by the weight returned one cycle later. After the last product it adds a bias and applies activation, then emits one fixed-point result per input vector. One instance sits beside each weight memory in a layer.

Parameters:
numWeights, 784, inputs per vector (weights per neuron)
addrWidth, 10, weight address width; must satisfy 2^addrWidth >= numWeights
dataWidth, 16, signed two's-complement width of activations, weights, bias, output
fracBits, 8, fractional bits of the Q format shared by data, weights and bias
biasValue, 0, signed dataWidth-bit bias in the same Q format

Ports:
clk        input   1          clock, rising edge
rst_n      input   1          asynchronous active-low reset
in_valid   input   1          activation valid
in_ready   output  1          block can accept an activation
in_data    input   dataWidth  signed activation
ren        output  1          weight memory read enable
raddr      output  addrWidth  weight memory read address
wout       input   dataWidth  signed weight from memory, valid 1 cycle after ren
out_valid  output  1          single-cycle result strobe
out_data   output  dataWidth  signed neuron result

Behaviour:
- Reset values (async, rst_n low):
  - state ACCUM, weight counter 0, accumulator 0, pipeline valid 0.
  - out_valid 0, out_data 0, in_ready 0, ren 0, raddr 0.
- in_ready goes high on the first clock edge after reset release.
- Accept = in_valid && in_ready.
  - ren = accept (combinational).
  - raddr = weight counter (registered).
- On an accept edge (E0):
  - in_data is registered into x_d and mul_vld is set.
  - The counter increments, or wraps to 0 after numWeights-1.
- The memory returns wout one cycle after ren.
- Accumulate: on the edge after mul_vld (E1), acc += x_d * wout.
  - The product is full 2*dataWidth signed.
  - acc is 2*dataWidth+8 bits signed; the addition saturates at acc bounds.
- States:
  - ACCUM:
    - Accepts inputs.
    - When the accepted sample is index numWeights-1, in_ready drops from E0.
    - The state goes to WAIT for one cycle while the last product accumulates, then to BIAS.
  - BIAS:
    - acc += biasValue sign-extended and aligned, i.e. shifted left by fracBits.
    - Next state OUT.
  - OUT:
    - r = acc arithmetically shifted right by fracBits, saturated to the dataWidth signed range [-2^(dataWidth-1), 2^(dataWidth-1)-1].
    - Activation is applied per the Optional Feature.
    - out_data <= result and out_valid <= 1 for exactly one cycle.
    - acc is cleared to 0, state returns to ACCUM, in_ready high.
- Latency: out_valid asserts in the cycle after edge E3, where E0 is the acceptance of the last sample (three edges).
  - in_ready is low for edges E1..E3.
  - in_ready is high again in the cycle where out_valid is high, so the next vector may start back-to-back.
- out_data holds its value until the next result; only out_valid pulses.
- Gaps in in_valid mid-vector are legal:
  - No accumulate happens on cycles without mul_vld.
  - raddr holds its value.
- in_data is ignored when in_ready is low.
- Reset asserted mid-vector: partial sum is discarded, the counter returns to 0, and no out_valid is produced for that vector.

Optional Feature:
NEURON_RELU_EN
- Defined: if the saturated r is negative, out_data = 0; otherwise out_data = r (ReLU, used in hidden layers).
- Undefined: out_data = r, signed linear pass-through (output layer, scores fed to argmax).

Test Plan:
Bench models the weight memory as a 1-cycle registered read. Parameters: numWeights=4, dataWidth=16, fracBits=8, biasValue=0 unless stated.
1. Weights {256,256,256,256}, inputs {256,512,-256,256} back-to-back -> raddr sequence 0,1,2,3; out_valid one cycle, 3 edges after last accept; out_data=768.
2. Weights all 256, inputs all -256 -> out_data=0 with NEURON_RELU_EN; out_data=-1024 (0xFC00) without.
3. biasValue=128, weights all 256, inputs all 64 -> 4*64+128 = out_data 384; with biasValue=-512, inputs all 64 -> -256 (linear build) / 0 (ReLU build).
4. Weights all 32767, inputs all 32767 -> out_data=32767 saturated; weights all -32768, inputs all 32767, linear build -> out_data=-32768.
5. Two vectors with in_valid held high continuously, plus random in_valid gaps -> in_ready low exactly 3 cycles per vector; both results correct; raddr wraps 3->0; no sample lost or double-counted.
6. Assert rst_n low after 2 of 4 samples, release, send full vector {256,256,256,256} with weights 256 -> all outputs at reset values during reset; single result 1024; no result for the aborted vector.
